// File: rtl/tune_pkg.sv
// Shared codes for the tuning-offset block.
// Holds the sys_status codes, tune field codes, key masks and the repeat FSM state type.
package tune_pkg;

    // sys_status codes that allow tuning
    localparam logic [2:0] S_TUNING      = 3'd3;
    localparam logic [2:0] S_ALARMTUNING = 3'd5;

    // tune_status field codes
    localparam logic [1:0] T_NONE   = 2'd0;
    localparam logic [1:0] T_SECOND = 2'd1;
    localparam logic [1:0] T_MINUTE = 2'd2;
    localparam logic [1:0] T_HOUR   = 2'd3;

    // single-key masks on neg_keys_filtered / key_held
    localparam logic [3:0] MV_LEFT  = 4'b0010;
    localparam logic [3:0] MV_RIGHT = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/tune_offset_rpt_sat_step.sv
// Clamped add/subtract of a step into a W-bit value.
// Ports:
//   value     current value
//   step      step magnitude (zero-extended by caller)
//   right     1 = add (clamp at all ones), 0 = subtract (clamp at zero)
//   result_c  stepped and clamped value
//   changed_c result differs from value
module sat_step #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic         right,
    output logic [W-1:0] result_c,
    output logic         changed_c
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit carries the overflow / borrow that triggers the clamp.
    assign sum  = {1'b0, value} + {1'b0, step};
    assign diff = {1'b0, value} - {1'b0, step};

    always_comb begin
        result_c = value;
        if (right) begin
            result_c = sum[W] ? '1 : sum[W-1:0];
        end else begin
            result_c = diff[W] ? '0 : diff[W-1:0];
        end
        changed_c = (result_c != value);
    end

endmodule

// File: rtl/tune_offset_rpt.sv
// Tuning-offset accumulator with hold-to-repeat.
// Moves a biased offset by hour/minute/second steps on left/right presses;
// a held key auto-repeats after RPT_DELAY cycles, then every RPT_PERIOD cycles.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   sys_status          system state (tuning enabled in S_TUNING / S_ALARMTUNING)
//   tune_status         field select: NONE / SECOND / MINUTE / HOUR
//   neg_keys_filtered   one-cycle debounced press pulses
//   key_held            debounced held levels
//   offset              biased offset (registered)
//   at_min, at_max      offset at zero / all ones (decoded from offset)
//   step_pulse          high in the first cycle offset shows a new stepped value
module tune_offset_rpt
    import tune_pkg::*;
#(
    parameter int unsigned          OFFSET_W    = 20,
    parameter logic [OFFSET_W-1:0]  OFFSET_INIT = {1'b0, {(OFFSET_W-1){1'b1}}},
    parameter int unsigned          STEP_H      = 3600,
    parameter int unsigned          STEP_M      = 60,
    parameter int unsigned          STEP_S      = 1,
    parameter int unsigned          RPT_DELAY   = 500,
    parameter int unsigned          RPT_PERIOD  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          sys_status,
    input  logic [1:0]          tune_status,
    input  logic [3:0]          neg_keys_filtered,
    input  logic [3:0]          key_held,
    output logic [OFFSET_W-1:0] offset,
    output logic                at_min,
    output logic                at_max,
    output logic                step_pulse
);

    localparam int unsigned CNT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    rpt_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                dir, dir_n;          // 1 = right
    logic [OFFSET_W-1:0] offset_n;
    logic                step_pulse_n;
    logic [1:0]          tune_prev;

    logic                active;
    logic                field_change;
    logic                press_left, press_right, press;
    logic                held;
    logic                do_step;
    logic                step_dir;
    logic [OFFSET_W-1:0] step_val;
    logic [OFFSET_W-1:0] stepped;
    logic                step_changed;

    assign active       = ((sys_status == S_TUNING) || (sys_status == S_ALARMTUNING))
                          && (tune_status != T_NONE);
    // Switching between two real fields drops the repeat but keeps the offset.
    assign field_change = (tune_prev != T_NONE) && (tune_status != tune_prev);
    assign press_left   = (neg_keys_filtered == MV_LEFT);
    assign press_right  = (neg_keys_filtered == MV_RIGHT);
    assign press        = press_left || press_right;
    assign held         = dir ? |(key_held & MV_RIGHT) : |(key_held & MV_LEFT);

    assign at_min = (offset == '0);
    assign at_max = (offset == '1);

    // Step size for the selected field.
    always_comb begin
        step_val = '0;
        case (tune_status)
            T_HOUR:   step_val = OFFSET_W'(STEP_H);
            T_MINUTE: step_val = OFFSET_W'(STEP_M);
            T_SECOND: step_val = OFFSET_W'(STEP_S);
            default:  step_val = '0;
        endcase
    end

    sat_step #(
        .W (OFFSET_W)
    ) u_sat_step (
        .value     (offset),
        .step      (step_val),
        .right     (step_dir),
        .result_c  (stepped),
        .changed_c (step_changed)
    );

    // Next-state, counter and offset update.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        dir_n        = dir;
        offset_n     = offset;
        step_pulse_n = 1'b0;
        do_step      = 1'b0;
        step_dir     = dir;

        if (!active) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            offset_n = OFFSET_INIT;
        end else if (field_change) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (press) begin
            // A fresh press restarts the sequence and beats any due repeat.
            do_step  = 1'b1;
            step_dir = press_right;
            dir_n    = press_right;
            cnt_n    = '0;
            state_n  = ST_HOLD;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CNT_W'(RPT_DELAY - 1)) begin
                        do_step = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_REPEAT;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == CNT_W'(RPT_PERIOD - 1)) begin
                        do_step = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        if (do_step) begin
            offset_n     = stepped;
            step_pulse_n = step_changed;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dir        <= 1'b0;
            offset     <= OFFSET_INIT;
            step_pulse <= 1'b0;
            tune_prev  <= T_NONE;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dir        <= dir_n;
            offset     <= offset_n;
            step_pulse <= step_pulse_n;
            tune_prev  <= tune_status;
        end
    end

endmodule

// File: tb/tb_tune_offset_rpt.sv
// Directed bench for tune_offset_rpt with RPT_DELAY=4, RPT_PERIOD=2.
module tb_tune_offset_rpt;

    localparam int unsigned W = 20;

    logic         clk;
    logic         rst_n;
    logic [2:0]   sys_status;
    logic [1:0]   tune_status;
    logic [3:0]   neg_keys_filtered;
    logic [3:0]   key_held;
    logic [W-1:0] offset;
    logic         at_min;
    logic         at_max;
    logic         step_pulse;

    int total;
    int bad;

    tune_offset_rpt #(
        .OFFSET_W   (W),
        .RPT_DELAY  (4),
        .RPT_PERIOD (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sys_status        (sys_status),
        .tune_status       (tune_status),
        .neg_keys_filtered (neg_keys_filtered),
        .key_held          (key_held),
        .offset            (offset),
        .at_min            (at_min),
        .at_max            (at_max),
        .step_pulse        (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle press pulse; key_held left as the caller set it.
    task automatic press(input logic [3:0] mask);
        neg_keys_filtered = mask;
        tick();
        neg_keys_filtered = 4'b0000;
    endtask

    initial begin
        logic [W-1:0] exp_off;
        logic         exp_p;
        total = 0;
        bad   = 0;

        rst_n             = 1'b0;
        sys_status        = 3'd3;
        tune_status       = 2'd3;
        neg_keys_filtered = 4'b0000;
        key_held          = 4'b0000;
        tick();
        tick();
        check("rst_offset", 32'(offset), 32'h7ffff);
        check("rst_pulse",  32'(step_pulse), 32'd0);
        check("rst_min",    32'(at_min), 32'd0);
        check("rst_max",    32'(at_max), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // 1: HOUR, single right press, held released next cycle
        key_held = 4'b0100;
        press(4'b0100);
        key_held = 4'b0000;
        check("t1_offset", 32'(offset), 32'h80e0f);
        check("t1_pulse",  32'(step_pulse), 32'd1);
        tick();
        check("t1_pulse_off", 32'(step_pulse), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("t1_idle_offset", 32'(offset), 32'h80e0f);
        check("t1_idle_pulse",  32'(step_pulse), 32'd0);

        // field change with a press in the same cycle: no step, offset kept
        tune_status       = 2'd2;
        neg_keys_filtered = 4'b0100;
        tick();
        neg_keys_filtered = 4'b0000;
        check("fc_offset", 32'(offset), 32'h80e0f);
        check("fc_pulse",  32'(step_pulse), 32'd0);
        sys_status = 3'd0;
        tick();
        check("leave_offset", 32'(offset), 32'h7ffff);
        sys_status = 3'd3;
        tick();

        // 2: MINUTE, left held for repeats at +1,+5,+7,+9,+11
        key_held = 4'b0010;
        press(4'b0010);
        exp_off = 20'h7ffc3;
        check("t2_c1_offset", 32'(offset), 32'(exp_off));
        check("t2_c1_pulse",  32'(step_pulse), 32'd1);
        for (int c = 2; c <= 11; c++) begin
            tick();
            exp_p = (c == 5) || (c == 7) || (c == 9) || (c == 11);
            if (exp_p) exp_off = exp_off - 20'd60;
            check($sformatf("t2_c%0d_pulse", c), 32'(step_pulse), 32'(exp_p));
            check($sformatf("t2_c%0d_offset", c), 32'(offset), 32'(exp_off));
        end
        key_held = 4'b0000;
        tick();
        check("t2_final_offset", 32'(offset), 32'h7fed3);
        check("t2_final_pulse",  32'(step_pulse), 32'd0);

        // 3: drive to zero with HOUR lefts, then SECOND to 2, then left clamp
        tune_status = 2'd3;
        tick();
        for (int i = 0; i < 150; i++) press(4'b0010);
        check("t3_zero", 32'(offset), 32'h0);
        check("t3_min0", 32'(at_min), 32'd1);
        tune_status = 2'd1;
        tick();
        press(4'b0100);
        check("t3_up1", 32'(offset), 32'h1);
        press(4'b0100);
        check("t3_up2", 32'(offset), 32'h2);
        press(4'b0010);
        check("t3_l1_offset", 32'(offset), 32'h1);
        check("t3_l1_pulse",  32'(step_pulse), 32'd1);
        press(4'b0010);
        check("t3_l2_offset", 32'(offset), 32'h0);
        check("t3_l2_pulse",  32'(step_pulse), 32'd1);
        press(4'b0010);
        check("t3_l3_offset", 32'(offset), 32'h0);
        check("t3_l3_pulse",  32'(step_pulse), 32'd0);
        check("t3_l3_min",    32'(at_min), 32'd1);

        // 4: clamp at the top
        sys_status = 3'd0;
        tick();
        sys_status  = 3'd3;
        tune_status = 2'd3;
        tick();
        for (int i = 0; i < 150; i++) press(4'b0100);
        check("t4_full", 32'(offset), 32'hfffff);
        tune_status = 2'd1;
        tick();
        for (int i = 0; i < 255; i++) press(4'b0010);
        check("t4_fff00", 32'(offset), 32'hfff00);
        check("t4_max0", 32'(at_max), 32'd0);
        tune_status = 2'd3;
        tick();
        press(4'b0100);
        check("t4_clamp_offset", 32'(offset), 32'hfffff);
        check("t4_clamp_pulse",  32'(step_pulse), 32'd1);
        check("t4_clamp_max",    32'(at_max), 32'd1);
        press(4'b0100);
        check("t4_again_offset", 32'(offset), 32'hfffff);
        check("t4_again_pulse",  32'(step_pulse), 32'd0);

        // 5: leave tuning during REPEAT (alarm tuning mode)
        sys_status = 3'd0;
        tick();
        sys_status = 3'd5;
        tick();
        key_held = 4'b0100;
        press(4'b0100);
        check("t5_c1", 32'(offset), 32'h80e0f);
        for (int i = 0; i < 4; i++) tick();
        check("t5_c5_offset", 32'(offset), 32'h81c1f);
        check("t5_c5_pulse",  32'(step_pulse), 32'd1);
        tick();
        sys_status = 3'd0;
        tick();
        check("t5_leave_offset", 32'(offset), 32'h7ffff);
        check("t5_leave_pulse",  32'(step_pulse), 32'd0);
        sys_status = 3'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t5_reenter%0d_pulse", i), 32'(step_pulse), 32'd0);
        end
        check("t5_reenter_offset", 32'(offset), 32'h7ffff);
        key_held = 4'b0000;
        tick();

        // 6a: multi-key pulse ignored
        key_held = 4'b0110;
        press(4'b0110);
        check("t6_multi_offset", 32'(offset), 32'h7ffff);
        check("t6_multi_pulse",  32'(step_pulse), 32'd0);
        key_held = 4'b0000;
        tick();
        tick();

        // 6b: right press on the cycle a left repeat is due
        key_held = 4'b0010;
        press(4'b0010);
        check("t6_l1", 32'(offset), 32'h7f1ef);
        for (int i = 0; i < 4; i++) tick();
        check("t6_l5", 32'(offset), 32'h7e3df);
        tick();
        key_held = 4'b0100;
        press(4'b0100);
        check("t6_r_offset", 32'(offset), 32'h7f1ef);
        check("t6_r_pulse",  32'(step_pulse), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("t6_r_wait", 32'(offset), 32'h7f1ef);
        tick();
        check("t6_r_rpt_offset", 32'(offset), 32'h7ffff);
        check("t6_r_rpt_pulse",  32'(step_pulse), 32'd1);

        // 6c: async reset mid-HOLD, key still held on release
        press(4'b0100);
        check("t6_pre_rst", 32'(offset), 32'h80e0f);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_offset", 32'(offset), 32'h7ffff);
        check("t6_rst_pulse",  32'(step_pulse), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t6_post%0d_pulse", i), 32'(step_pulse), 32'd0);
        end
        check("t6_post_offset", 32'(offset), 32'h7ffff);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tune_offset_rpt.md
Name: tune_offset_rpt

Overview:
Parametrised tuning-offset accumulator with hold-to-repeat for the digital clock's time and alarm tuning modes. Moves a biased offset register by hour, minute or second steps on left/right key presses. Holding a key auto-repeats after a delay. Sits between the key filter and the time/alarm counters, which add (offset − OFFSET_INIT) on commit.

Parameters:
OFFSET_W, 20, offset register width
OFFSET_INIT, 2^(OFFSET_W-1)−1 (20'h7ffff), neutral/bias value
STEP_H, 3600, step for T_HOUR
STEP_M, 60, step for T_MINUTE
STEP_S, 1, step for T_SECOND
RPT_DELAY, 500, cycles a key is held before the first auto-repeat (≥2)
RPT_PERIOD, 100, cycles between auto-repeats (≥1)
S_TUNING, 3'd3; S_ALARMTUNING, 3'd5, sys_status codes that enable tuning
MV_LEFT, 4'b0010; MV_RIGHT, 4'b0100, key masks

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sys_status  in  3  system state
tune_status  in  2  field select: 0 NONE, 1 SECOND, 2 MINUTE, 3 HOUR
neg_keys_filtered  in  4  one-cycle press pulses, debounced
key_held  in  4  debounced held level, active-high
offset  out  OFFSET_W  biased offset
at_min  out  1  offset == 0
at_max  out  1  offset == all ones
step_pulse  out  1  high for exactly the cycle in which offset first shows a new stepped value

Behaviour:
- Reset: offset=OFFSET_INIT, FSM=IDLE, repeat counter=0, step_pulse=0. at_min and at_max are combinational from offset.
- Tuning is active when sys_status is S_TUNING or S_ALARMTUNING and tune_status≠NONE. When tuning is inactive, on the next edge: offset=OFFSET_INIT, FSM=IDLE, counter=0.
- Step size comes from the current tune_status (HOUR/MINUTE/SECOND), zero-extended to OFFSET_W.
- Step arithmetic saturates by clamping:
  - Left: offset<step → 0, else offset−step.
  - Right: offset>max−step → max, else offset+step.
  - Use an OFFSET_W+1 intermediate.
  - step_pulse asserts only if the value actually changed (no pulse when already at the clamp).
- Direction is valid only when neg_keys_filtered equals MV_LEFT or MV_RIGHT exactly. Any other value, including multi-bit, is ignored as a press.
- FSM states:
  - IDLE: valid press → apply one step (visible the next cycle), latch dir, counter=0, go to HOLD.
  - HOLD: counter increments each cycle. The key_held bit for the latched dir is low → IDLE. counter==RPT_DELAY−1 → apply step, counter=0, go to REPEAT.
  - REPEAT: counter increments. Held bit low → IDLE. counter==RPT_PERIOD−1 → apply step, counter=0.
- A valid press in HOLD or REPEAT (either direction) restarts the sequence exactly as from IDLE: one step, new dir, HOLD, counter=0. This press takes priority over a repeat due in the same cycle.
- A tune_status change between non-NONE fields → FSM=IDLE, offset kept, no step that cycle.
- Latency: press pulse at edge N → offset updated and step_pulse high after edge N+1. Holding from the press cycle gives a first repeat RPT_DELAY cycles after the initial step, then one every RPT_PERIOD cycles.
- Reset asserted mid-repeat → immediate return to reset values; no step on release.

Decomposition:
- Shared package tune_pkg holds:
  - sys_status codes S_TUNING and S_ALARMTUNING
  - tune field codes T_NONE, T_SECOND, T_MINUTE, T_HOUR
  - key masks MV_LEFT and MV_RIGHT
  - FSM state typedef (IDLE/HOLD/REPEAT)
- One natural sub-module: sat_step (combinational clamped add/sub of a step into OFFSET_W bits, with a changed flag).

Test Plan (OFFSET_W=20, RPT_DELAY=4, RPT_PERIOD=2 unless noted):
1. Tuning, HOUR; MV_RIGHT pulse with key_held released the next cycle → offset 0x7ffff→0x80e0f (+3600); single step_pulse; FSM back in IDLE.
2. Tuning, MINUTE; MV_LEFT pulse with the held bit kept high for 10 cycles → steps at +1, +5, +7, +9, +11 cycles → offset 0x7ffff−300=0x7fed3.
3. SECOND, offset forced to 2 by earlier presses; three MV_LEFT presses → offset 1, 0, 0; third press gives no step_pulse; at_min=1.
4. Near the top, HOUR, offset=0xfff00; MV_RIGHT → 0xfffff (clamped); at_max=1; a further press gives no pulse.
5. sys_status leaves tuning during REPEAT → next cycle offset=0x7ffff, FSM IDLE; re-entering tuning with the key still held causes no step.
6. Multi-key pulse 4'b0110 → no change; MV_RIGHT during a left repeat → immediate +step and dir=right; rst_n low mid-HOLD → offset=0x7ffff asynchronously.
